sprite_blitter: RTL
===================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter VRAM_A_WIDTH, default 16: frame-buffer address width.
REQ-002 SHALL have parameter SCREEN_WIDTH, default 320, and SCREEN_HEIGHT, default 180: visible area in pixels.
REQ-003 SHALL have parameter SPRITE_SIZE, default 32: square sprite edge length in pixels.
REQ-004 SHALL have parameter SPRITEBUF_A_WIDTH, default 13, and SPRITEBUF_D_WIDTH, default 8: sprite-ROM address and data widths.
REQ-005 SHALL have ports, clock and reset first:
- CLK  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  blit request, level, held until o_ack.
- i_sprite_index  in  3  sprite slot, 0-7.
- i_pos_x  in  10  top-left x, unsigned.
- i_pos_y  in  10  top-left y, unsigned.
- o_ack  out  1  one-cycle pulse: request accepted.
- o_busy  out  1  blit in progress.
- o_done  out  1  one-cycle pulse: all writes issued.
- o_sprite_addr  out  SPRITEBUF_A_WIDTH  sprite-ROM address.
- i_sprite_data  in  SPRITEBUF_D_WIDTH  palette index, valid 1 cycle after address.
- i_sprite_alpha  in  1  opacity bit, valid 1 cycle after address.
- o_vram_addr  out  VRAM_A_WIDTH  back-buffer write address.
- o_vram_data  out  SPRITEBUF_D_WIDTH  back-buffer write data.
- o_vram_we  out  1  back-buffer write enable.

Function
REQ-006 SHALL have states IDLE, RUN, DRAIN and DONE; every output is registered.
REQ-007 SHALL, in IDLE with i_req=1 at a clock edge, latch index and position, enter RUN, and assert o_ack for exactly the next cycle (cycle A).
REQ-008 SHALL ignore i_req in RUN, DRAIN and DONE, and assert o_busy in RUN and DRAIN only.
REQ-009 SHALL, in RUN, present o_sprite_addr = index*SPRITE_SIZE^2 + row*SPRITE_SIZE + col, starting at row=col=0 in cycle A, one address per cycle, col fastest, ending at A+1023.
REQ-010 SHALL register each ROM word into o_vram_* two cycles after its address was presented.
REQ-011 SHALL drive o_vram_addr = (pos_y+row)*SCREEN_WIDTH + (pos_x+col), truncated to VRAM_A_WIDTH.
REQ-012 SHALL force o_vram_we=0 for any pixel with pos_x+col >= SCREEN_WIDTH or pos_y+row >= SCREEN_HEIGHT (clipping, no wrap).
REQ-013 SHALL hold DRAIN for 2 cycles after the last address, then enter DONE for one cycle with o_done=1 and o_busy=0 (cycle A+1026), then return to IDLE.
REQ-014 SHALL accept a request sampled at the edge ending DONE, so that o_ack follows o_done back-to-back.
REQ-015 SHALL, when latched pos_x >= SCREEN_WIDTH or pos_y >= SCREEN_HEIGHT, skip RUN and DRAIN: o_done is asserted at A+1 and no write is issued.
REQ-016 SHALL hold o_vram_we=0 in IDLE and DONE.

Reset
REQ-017 SHALL, while rst=0, immediately force state IDLE and all outputs and counters to 0, including mid-blit; no write is issued after rst falls.
REQ-018 SHALL resume in IDLE on the first edge after rst rises, with no pending request remembered.

Configuration
REQ-019 SHALL, with macro SPRITE_BLIT_ALPHA_EN defined, gate o_vram_we with the i_sprite_alpha of the same pixel, so transparent pixels are skipped.
REQ-020 SHALL, without SPRITE_BLIT_ALPHA_EN, ignore i_sprite_alpha and write every on-screen pixel (opaque blit for backgrounds); timing is unchanged.

Verification
REQ-021 SHALL cover: index 0 at (0,0), all alpha 1 -> 1024 writes, first addr 0, last addr 9951, o_done at A+1026.
REQ-022 SHALL cover: index 1 at (300,170) -> 200 writes (20 cols x 10 rows), first addr 54700, first ROM addr 1024, no addr >= 57600.
REQ-023 SHALL cover: request at (320,5) -> o_ack, then o_done on the next cycle, zero writes.
REQ-024 SHALL cover: checkerboard alpha at (10,10) -> 512 writes with SPRITE_BLIT_ALPHA_EN, 1024 without.
REQ-025 SHALL cover: rst low during row 5 -> o_vram_we, o_busy and o_ack go to 0 immediately; after release, a new request at (0,0) completes per REQ-021.
REQ-026 SHALL cover: i_req held high across two blits -> second o_ack in the cycle after first o_done, with no extra o_ack while busy.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one SPRITE_SIZE x SPRITE_SIZE sprite from ROM into the back buffer, with screen-edge clipping.
// Define SPRITE_BLIT_ALPHA_EN to skip transparent pixels; without it every on-screen pixel is written.
module sprite_blitter #(
    parameter int VRAM_A_WIDTH      = 16,
    parameter int SCREEN_WIDTH      = 320,
    parameter int SCREEN_HEIGHT     = 180,
    parameter int SPRITE_SIZE       = 32,
    parameter int SPRITEBUF_A_WIDTH = 13,
    parameter int SPRITEBUF_D_WIDTH = 8
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [2:0]                   i_sprite_index,
    input  logic [9:0]                   i_pos_x,
    input  logic [9:0]                   i_pos_y,
    output logic                         o_ack,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [SPRITEBUF_A_WIDTH-1:0] o_sprite_addr,
    input  logic [SPRITEBUF_D_WIDTH-1:0] i_sprite_data,
    input  logic                         i_sprite_alpha,
    output logic [VRAM_A_WIDTH-1:0]      o_vram_addr,
    output logic [SPRITEBUF_D_WIDTH-1:0] o_vram_data,
    output logic                         o_vram_we
);

    localparam int CW          = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
    localparam int SPRITE_AREA = SPRITE_SIZE * SPRITE_SIZE;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                      state_reg;
    logic [2:0]                  index_reg;
    logic [9:0]                  pos_x_reg;
    logic [9:0]                  pos_y_reg;
    logic                        skip_reg;
    logic [CW-1:0]               row_reg;
    logic [CW-1:0]               col_reg;
    logic                        drain_reg;
    logic [VRAM_A_WIDTH-1:0]     s1_addr_reg;
    logic                        s1_valid_reg;

    logic [31:0]                 x_sum;
    logic [31:0]                 y_sum;
    logic [VRAM_A_WIDTH-1:0]     vram_addr_next;
    logic                        on_screen;
    logic                        last_col;
    logic                        last_pix;
    logic                        off_screen_req;
    logic [SPRITEBUF_A_WIDTH-1:0] sprite_base;
    logic                        alpha_gate;

    assign x_sum          = 32'(pos_x_reg) + 32'(col_reg);
    assign y_sum          = 32'(pos_y_reg) + 32'(row_reg);
    assign vram_addr_next = VRAM_A_WIDTH'(y_sum * 32'(SCREEN_WIDTH) + x_sum);
    assign on_screen      = (x_sum < 32'(SCREEN_WIDTH)) && (y_sum < 32'(SCREEN_HEIGHT));
    assign last_col       = (col_reg == CW'(SPRITE_SIZE - 1));
    assign last_pix       = last_col && (row_reg == CW'(SPRITE_SIZE - 1));
    assign off_screen_req = (32'(i_pos_x) >= 32'(SCREEN_WIDTH)) || (32'(i_pos_y) >= 32'(SCREEN_HEIGHT));
    assign sprite_base    = SPRITEBUF_A_WIDTH'(32'(i_sprite_index) * 32'(SPRITE_AREA));

`ifdef SPRITE_BLIT_ALPHA_EN
    assign alpha_gate = i_sprite_alpha;
`else
    logic unused_alpha;
    assign unused_alpha = i_sprite_alpha;
    assign alpha_gate   = 1'b1;
`endif

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            pos_x_reg     <= '0;
            pos_y_reg     <= '0;
            skip_reg      <= 1'b0;
            row_reg       <= '0;
            col_reg       <= '0;
            drain_reg     <= 1'b0;
            s1_addr_reg   <= '0;
            s1_valid_reg  <= 1'b0;
            o_ack         <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_sprite_addr <= '0;
            o_vram_addr   <= '0;
            o_vram_data   <= '0;
            o_vram_we     <= 1'b0;
        end else begin
            o_ack        <= 1'b0;
            o_done       <= 1'b0;
            // Stage 2: ROM word for the pixel addressed two cycles ago arrives now.
            o_vram_addr  <= s1_addr_reg;
            o_vram_data  <= i_sprite_data;
            o_vram_we    <= s1_valid_reg & alpha_gate;
            // Stage 1: destination of the pixel whose ROM address is on the bus.
            s1_addr_reg  <= vram_addr_next;
            s1_valid_reg <= 1'b0;

            case (state_reg)
                IDLE, DONE: begin
                    if (i_req) begin
                        index_reg     <= i_sprite_index;
                        pos_x_reg     <= i_pos_x;
                        pos_y_reg     <= i_pos_y;
                        skip_reg      <= off_screen_req;
                        row_reg       <= '0;
                        col_reg       <= '0;
                        o_sprite_addr <= sprite_base;
                        o_ack         <= 1'b1;
                        o_busy        <= 1'b1;
                        state_reg     <= RUN;
                    end else begin
                        state_reg     <= IDLE;
                    end
                end
                RUN: begin
                    if (skip_reg) begin
                        o_done    <= 1'b1;
                        o_busy    <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        s1_valid_reg <= on_screen;
                        if (last_col) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                        if (last_pix) begin
                            drain_reg <= 1'b0;
                            state_reg <= DRAIN;
                        end else begin
                            o_sprite_addr <= o_sprite_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles let the final ROM word travel through both stages.
                    if (drain_reg) begin
                        o_done    <= 1'b1;
                        o_busy    <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        drain_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
